// File: rtl/key_matrix_scanner_pkg.sv
// Shared types and width helpers for the key matrix scanner.
package key_scan_pkg;

  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    EVAL   = 2'd3
  } scan_state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Counter/index widths never collapse to zero bits, even for a count of 1.
  function automatic int width_of(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

  function automatic int code_width(input int rows, input int cols);
    return width_of(rows * cols);
  endfunction

endpackage

// File: rtl/key_matrix_scanner_cdc_sync2.sv
// Two-flop synchronizer for bringing asynchronous column lines into the clk domain.
module cdc_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/key_matrix_scanner.sv
// Row-scanning keypad reader: per-key debounce, press/release events over valid/ready.
module key_matrix_scanner
  import key_scan_pkg::*;
#(
  parameter  int ROWS           = 8,
  parameter  int COLS           = 8,
  parameter  int SETTLE_CYCLES  = 27000,
  parameter  int DEBOUNCE_SCANS = 3,
  localparam int CODE_W         = code_width(ROWS, COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ROWS-1:0]      row_drive,
  input  logic [COLS-1:0]      col_sense,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [CODE_W-1:0]    ev_code,
  output logic                 ev_press,
  output logic [ROWS*COLS-1:0] key_state
);

  localparam int KEYS  = ROWS * COLS;
  localparam int ROW_W = width_of(ROWS);
  localparam int COL_W = width_of(COLS);
  localparam int TMR_W = width_of(SETTLE_CYCLES);
  localparam int CNT_W = width_of(DEBOUNCE_SCANS + 1);

  scan_state_e        state_q, state_d;
  logic [ROW_W-1:0]   row_idx_q, row_idx_d;
  logic [COL_W-1:0]   col_idx_q, col_idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ROWS-1:0]    row_drive_q, row_drive_d;
  logic [COLS-1:0]    samp_q, samp_d;
  logic               ev_valid_q, ev_valid_d;
  logic [CODE_W-1:0]  ev_code_q, ev_code_d;
  logic               ev_press_q, ev_press_d;
  logic [KEYS-1:0]    stable_q, stable_d;
  logic [CNT_W-1:0]   cnt_q [KEYS];

  logic [COLS-1:0]    col_sync;
  logic [CODE_W-1:0]  key_idx;
  logic               samp_bit;
  logic [CNT_W-1:0]   cnt_plus;
  logic               blocked;
  logic               cnt_we;
  logic [CNT_W-1:0]   cnt_wdata;

  cdc_sync2 #(
    .WIDTH (COLS)
  ) u_col_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (col_sense),
    .sync_o  (col_sync)
  );

  assign key_idx  = CODE_W'(row_idx_q) * CODE_W'(COLS) + CODE_W'(col_idx_q);
  assign samp_bit = samp_q[col_idx_q];
  assign cnt_plus = cnt_q[key_idx] + 1'b1;
  assign blocked  = ev_valid_q && !ev_ready;

  // A held event freezes EVAL on the current key, so the row stays driven
  // and no later key can overwrite the pending slot.
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    timer_d     = timer_q;
    row_drive_d = row_drive_q;
    samp_d      = samp_q;
    ev_valid_d  = ev_valid_q;
    ev_code_d   = ev_code_q;
    ev_press_d  = ev_press_q;
    stable_d    = stable_q;
    cnt_we      = 1'b0;
    cnt_wdata   = '0;

    if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end

    case (state_q)
      DRIVE: begin
        row_drive_d = ROWS'(1) << row_idx_q;
        timer_d     = '0;
        state_d     = SETTLE;
      end
      SETTLE: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TMR_W'(SETTLE_CYCLES - 1)) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        samp_d    = col_sync;
        col_idx_d = '0;
        state_d   = EVAL;
      end
      EVAL: begin
        if (!blocked) begin
          cnt_we = 1'b1;
          if (samp_bit == stable_q[key_idx]) begin
            cnt_wdata = '0;
          end else if (cnt_plus == CNT_W'(DEBOUNCE_SCANS)) begin
            stable_d[key_idx] = samp_bit;
            cnt_wdata         = '0;
            ev_valid_d        = 1'b1;
            ev_code_d         = key_idx;
            ev_press_d        = samp_bit;
          end else begin
            cnt_wdata = cnt_plus;
          end

          if (col_idx_q == COL_W'(COLS - 1)) begin
            row_idx_d = (row_idx_q == ROW_W'(ROWS - 1)) ? '0 : row_idx_q + 1'b1;
            state_d   = DRIVE;
          end else begin
            col_idx_d = col_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = DRIVE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DRIVE;
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      timer_q     <= '0;
      row_drive_q <= '0;
      samp_q      <= '0;
      ev_valid_q  <= 1'b0;
      ev_code_q   <= '0;
      ev_press_q  <= 1'b0;
      stable_q    <= '0;
      for (int i = 0; i < KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      timer_q     <= timer_d;
      row_drive_q <= row_drive_d;
      samp_q      <= samp_d;
      ev_valid_q  <= ev_valid_d;
      ev_code_q   <= ev_code_d;
      ev_press_q  <= ev_press_d;
      stable_q    <= stable_d;
      if (cnt_we) begin
        cnt_q[key_idx] <= cnt_wdata;
      end
    end
  end

  assign row_drive = row_drive_q;
  assign ev_valid  = ev_valid_q;
  assign ev_code   = ev_code_q;
  assign ev_press  = ev_press_q;
  assign key_state = stable_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner on a 4x4 matrix with short settle time.
module tb_key_matrix_scanner;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int SETTLE = 4;
  localparam int DEB    = 3;
  localparam int FRAME  = 40;

  logic        clk;
  logic        rst;
  logic [3:0]  rowDrive;
  logic [3:0]  colSense;
  logic        evValid;
  logic        evReady;
  logic [3:0]  evCode;
  logic        evPress;
  logic [15:0] keyState;

  logic [15:0] pressed;
  int          total;
  int          bad;
  int          accCount;
  logic [3:0]  lastCode;
  logic        lastPress;

  key_matrix_scanner #(
    .ROWS           (ROWS),
    .COLS           (COLS),
    .SETTLE_CYCLES  (SETTLE),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_drive (rowDrive),
    .col_sense (colSense),
    .ev_valid  (evValid),
    .ev_ready  (evReady),
    .ev_code   (evCode),
    .ev_press  (evPress),
    .key_state (keyState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: a closed key connects its driven row onto its column line.
  always_comb begin
    colSense = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (rowDrive[r] && pressed[r*COLS+c]) colSense[c] = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input logic rdy);
    pressed = keys;
    evReady = rdy;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    accCount = 0;
  endtask

  // Advance n cycles, logging every event handed to the consumer.
  task automatic runCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (evValid && evReady) begin
        accCount++;
        lastCode  = evCode;
        lastPress = evPress;
      end
    end
  endtask

  task automatic waitValid(input string tag, input int budget);
    int n;
    n = 0;
    while (!evValid && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(evValid), 32'd1);
  endtask

  task automatic waitRow(input string tag, input logic [3:0] row, input int budget);
    int n;
    n = 0;
    while (rowDrive !== row && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(rowDrive), 32'(row));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    accCount  = 0;
    lastCode  = '0;
    lastPress = 1'b0;
    rst       = 1'b1;
    applyStimulus(16'h0000, 1'b1);

    // Reset state and idle row walk
    doReset();
    checkOutput("rst_row", 32'(rowDrive), 32'd0);
    checkOutput("rst_valid", 32'(evValid), 32'd0);
    checkOutput("rst_code", 32'(evCode), 32'd0);
    checkOutput("rst_press", 32'(evPress), 32'd0);
    checkOutput("rst_state", 32'(keyState), 32'd0);
    for (int i = 1; i <= FRAME + 1; i++) begin
      runCycles(1);
      checkOutput($sformatf("walk_row_%0d", i), 32'(rowDrive),
                  32'(4'b0001 << (((i - 1) / 10) % 4)));
    end
    checkOutput("walk_no_event", accCount, 0);

    // Key 9 held for three frames: one press event in the third frame
    applyStimulus(16'h0200, 1'b1);
    doReset();
    runCycles(2 * FRAME);
    checkOutput("k9_early_events", accCount, 0);
    checkOutput("k9_early_state", 32'(keyState), 32'd0);
    runCycles(FRAME);
    checkOutput("k9_press_count", accCount, 1);
    checkOutput("k9_press_code", 32'(lastCode), 32'd9);
    checkOutput("k9_press_dir", 32'(lastPress), 32'd1);
    checkOutput("k9_press_state", 32'(keyState), 32'h0200);

    // Release key 9 for three frames: one release event
    applyStimulus(16'h0000, 1'b1);
    accCount = 0;
    runCycles(3 * FRAME);
    checkOutput("k9_rel_count", accCount, 1);
    checkOutput("k9_rel_code", 32'(lastCode), 32'd9);
    checkOutput("k9_rel_dir", 32'(lastPress), 32'd0);
    checkOutput("k9_rel_state", 32'(keyState), 32'd0);

    // Short press (two frames) then release: bounce is swallowed
    applyStimulus(16'h0200, 1'b1);
    doReset();
    runCycles(2 * FRAME);
    applyStimulus(16'h0000, 1'b1);
    runCycles(2 * FRAME);
    checkOutput("bounce_count", accCount, 0);
    checkOutput("bounce_state", 32'(keyState), 32'd0);

    // Backpressure: keys 4 and 7 held with consumer not ready
    applyStimulus(16'h0090, 1'b0);
    doReset();
    runCycles(3 * FRAME);
    checkOutput("bp_valid", 32'(evValid), 32'd1);
    checkOutput("bp_code", 32'(evCode), 32'd4);
    checkOutput("bp_press", 32'(evPress), 32'd1);
    checkOutput("bp_row", 32'(rowDrive), 32'b0010);
    checkOutput("bp_state", 32'(keyState), 32'h0010);
    runCycles(5);
    checkOutput("bp_hold_code", 32'(evCode), 32'd4);
    checkOutput("bp_hold_row", 32'(rowDrive), 32'b0010);
    applyStimulus(16'h0090, 1'b1);
    @(negedge clk);
    applyStimulus(16'h0090, 1'b0);
    checkOutput("bp_drained", 32'(evValid), 32'd0);
    waitValid("bp_ev7", 20);
    checkOutput("bp_ev7_code", 32'(evCode), 32'd7);
    checkOutput("bp_ev7_press", 32'(evPress), 32'd1);
    checkOutput("bp_ev7_state", 32'(keyState), 32'h0090);
    waitRow("bp_resume_row", 4'b0100, 20);
    checkOutput("bp_ev7_held", 32'(evCode), 32'd7);

    // Reset while an event is pending in EVAL
    applyStimulus(16'h0001, 1'b0);
    doReset();
    runCycles(100);
    checkOutput("mid_valid_before", 32'(evValid), 32'd1);
    checkOutput("mid_code_before", 32'(evCode), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_valid_after", 32'(evValid), 32'd0);
    checkOutput("mid_state_after", 32'(keyState), 32'd0);
    checkOutput("mid_row_after", 32'(rowDrive), 32'd0);
    rst = 1'b0;
    applyStimulus(16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("mid_restart_row", 32'(rowDrive), 32'b0001);
    checkOutput("mid_restart_valid", 32'(evValid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
